// File: rtl/g_piso8.sv
// Parallel-in / serial-out shifter: one WIDTH-bit word in, one bit out per CE strobe.
// Latency: first bit on SO the cycle after the accepting edge; DONE the cycle after the last CE.
// Backpressure: RDY (combinational) is high in IDLE or on the last-bit cycle when CE=1; LD otherwise ignored.
module g_piso8 #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             CK,
    input  logic             CD,
    input  logic [WIDTH-1:0] D,
    input  logic             LD,
    input  logic             CE,
    output logic             RDY,
    output logic             SO,
    output logic             SOV,
    output logic             FR,
    output logic             DONE
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             so_q, so_d;
    logic             sov_q, sov_d;
    logic             fr_q, fr_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             rdy;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            so_q    <= 1'b0;
            sov_q   <= 1'b0;
            fr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
            sov_q   <= sov_d;
            fr_q    <= fr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        last_bit = (state_q == SHIFT) && (cnt_q == '0) && CE;
        rdy      = (state_q == IDLE) || last_bit;
        done_d   = last_bit;

        case (state_q)
            IDLE: begin
                if (LD) begin
                    sr_d    = D;
                    cnt_d   = CNT_LAST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (CE) begin
                    if (cnt_q != '0) begin
                        sr_d  = advance(sr_q);
                        cnt_d = cnt_q - 1'b1;
                    end else if (LD) begin
                        // Gapless streaming: next word replaces the finished one in place.
                        sr_d  = D;
                        cnt_d = CNT_LAST;
                    end else begin
                        sr_d    = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so SO/SOV/FR come straight off flops.
        sov_d = (state_d == SHIFT);
        fr_d  = (state_d == SHIFT);
        so_d  = (state_d == SHIFT) ? head(sr_d) : 1'b0;
    end

    assign RDY  = rdy;
    assign SO   = so_q;
    assign SOV  = sov_q;
    assign FR   = fr_q;
    assign DONE = done_q;
endmodule
